serial_add_ctrl: RTL and testbench

//  Bit-serial adder controller. Accepts two WIDTH-bit operands plus carry-in over
//  a valid/ready handshake. Reuses one 1-bit full adder (two halfadder cells) once
//  per cycle, LSB first, for WIDTH cycles. Returns sum/cout over a valid/ready

---
 rtl/serial_add_pkg.sv | 8 +
 rtl/serial_add_ctrl_fulladder.sv | 28 ++
 rtl/serial_add_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

    localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_fulladder.sv
// One-bit full adder built from two half-adder cells; this is the only
// adder logic in the serial adder datapath.
module halfadder (
    input  logic A,
    input  logic B,
    output logic S,
    output logic C
);
    assign S = A ^ B;
    assign C = A & B;
endmodule

module fulladder (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic S,
    output logic Co
);
    logic s1;
    logic c1;
    logic c2;

    halfadder u_ha0 (.A(A),  .B(B),  .S(s1), .C(c1));
    halfadder u_ha1 (.A(s1), .B(Ci), .S(S),  .C(c2));

    assign Co = c1 | c2;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: accepts operands over valid/ready, adds them
// LSB first through one shared full adder, returns sum/cout over valid/ready.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// RUN   | one operand bit per cycle through the full adder
// DONE  | out_valid=1, result held until out_ready
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    sa_state_t        state;
    sa_state_t        state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_sh_nxt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic             last_bit;

    fulladder u_fa (
        .A (a_sh[0]),
        .B (b_sh[0]),
        .Ci(carry),
        .S (fa_s),
        .Co(fa_co)
    );

    // New bit enters at the MSB so the LSB-first stream lands in order.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_sh_nxt = fa_s;
        end else begin : g_wn
            assign sum_sh_nxt = {fa_s, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_sh_nxt;
                    carry  <= fa_co;
                    cnt    <= cnt + CW'(1);
                    // Output registers move only when the final bit completes.
                    if (last_bit) begin
                        sum_q  <= sum_sh_nxt;
                        cout_q <= fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: directed and random operations on a
// WIDTH=8 instance, plus exhaustive operands on a WIDTH=1 instance.
module tb_serial_add_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W:0] res;
        int         acc_cyc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    logic in_valid1, in_ready1, a1, b1, cin1, out_valid1, out_ready1, sum1, cout1, busy1;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   n_res = 0;
    int   cyc   = 0;
    bit   rand_ready_en = 0;

    serial_add_ctrl #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain unsigned addition, widened by one bit for the carry.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t e;
        e.res     = ref_add(x, y, c);
        e.acc_cyc = cyc + 1;
        sb_q.push_back(e);
        n_acc++;
    endtask

    task automatic issue_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                            input bit drop);
        bit taken = 0;
        a        = x;
        b        = y;
        cin      = c;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !taken; i++) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(x, y, c);
                taken = 1;
            end
        end
        if (!taken) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (drop) in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        check(name, sb_q.size(), 0);
    endtask

    // Monitor: latency on each result, hold under backpressure, value on handoff.
    initial begin
        logic         prev_valid = 0;
        logic         prev_ready = 0;
        logic [W:0]   held = '0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 0;
            end else begin
                if (out_valid && !prev_valid && sb_q.size() > 0)
                    check("latency", cyc - sb_q[0].acc_cyc, W);
                if (out_valid && prev_valid && !prev_ready)
                    check("hold_stable", {cout, sum}, held);
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("result", {cout, sum}, e.res);
                    end
                    n_res++;
                end
                prev_valid = out_valid;
                prev_ready = out_ready;
                held       = {cout, sum};
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready_en) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel;
        int acc;
        int acc_base;
        int res_base;
        bit taken;
        rst_n = 0; in_valid = 0; a = '0; b = '0; cin = 0; out_ready = 1;
        in_valid1 = 0; a1 = 0; b1 = 0; cin1 = 0; out_ready1 = 1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_busy", busy, 0);
        check("rst_w1_in_ready", in_ready1, 1);
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // 1: simple add, result kept through IDLE
        issue_op(8'h35, 8'h4A, 1'b0, 1);
        wait_drain("drain_t1");
        check("t1_idle_ready", in_ready, 1);
        check("t1_idle_sum", {cout, sum}, 9'h07F);

        // 2: full carry ripple
        issue_op(8'hFF, 8'h01, 1'b0, 1);
        issue_op(8'hFF, 8'hFF, 1'b1, 1);
        wait_drain("drain_t2");

        // 3: backpressure with a competing op on the input
        out_ready = 0;
        issue_op(8'h10, 8'h20, 1'b0, 0);
        a = 8'h11; b = 8'h22; cin = 1'b1;
        taken = 0;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge clk);
            if (out_valid) taken = 1;
        end
        check("t3_out_valid_seen", taken, 1);
        for (int i = 0; i < 5; i++) begin
            check("t3_in_ready_low", in_ready, 0);
            check("t3_busy", busy, 1);
            check("t3_sum_held", {cout, sum}, 9'h030);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1;
        rel = cyc;
        taken = 0;
        acc = 0;
        for (int i = 0; i < 20 && !taken; i++) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(8'h11, 8'h22, 1'b1);
                acc = cyc + 1;
                taken = 1;
            end
        end
        check("t3_accept_delay", acc, rel + 2);
        @(posedge clk);
        #1;
        in_valid = 0;
        wait_drain("drain_t3");

        // 4: reset in the third RUN cycle discards the op
        issue_op(8'hAA, 8'h55, 1'b0, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        check("t4_out_valid", out_valid, 0);
        check("t4_sum", sum, 0);
        check("t4_in_ready", in_ready, 1);
        check("t4_busy", busy, 0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1;
        taken = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) taken = 1;
        end
        check("t4_no_stale_valid", taken, 0);
        @(posedge clk);
        #1;
        issue_op(8'h01, 8'h02, 1'b0, 1);
        wait_drain("drain_t4");

        // 5: random ops with random backpressure
        acc_base = n_acc;
        res_base = n_res;
        rand_ready_en = 1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            issue_op(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 1) == 1));
        end
        in_valid = 0;
        rand_ready_en = 0;
        @(posedge clk);
        #1;
        out_ready = 1;
        wait_drain("drain_t5");
        check("t5_count", n_res - res_base, n_acc - acc_base);
        check("t5_ops", n_acc - acc_base, 200);

        // 6: WIDTH=1, every operand combination
        for (int v = 0; v < 8; v++) begin
            a1 = v[0]; b1 = v[1]; cin1 = v[2];
            in_valid1 = 1;
            @(negedge clk);
            check("t6_in_ready", in_ready1, 1);
            @(posedge clk);
            #1;
            in_valid1 = 0;
            @(negedge clk);
            check("t6_run_no_valid", out_valid1, 0);
            @(negedge clk);
            check("t6_out_valid", out_valid1, 1);
            check("t6_result", {cout1, sum1}, 32'(v[0]) + 32'(v[1]) + 32'(v[2]));
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
